dmem_access_unit: RTL

- Sequential load/store access unit between the core's memory stage and the word-addressed data memory.
- Generalises size/sign mask generation:
  - parametrised datapath width;
  - byte-enable generation;
  - read-data alignment with sign/zero extension;
  - optional splitting of misaligned accesses into two memory transactions.
- Uses a valid/ready request handshake and a single-cycle response pulse.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_access_unit_if.sv | 36 +++
 rtl/dmem_load_extend.sv | 34 +++
 rtl/dmem_access_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit: funct3 sizes, FSM states
// and the byte-enable helper used for both halves of a split access.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC0 = 2'b01,
    ST_ACC1 = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Two-word-wide enable mask: low BYTES bits serve the first access, the
  // next BYTES bits are the lanes spilling into the following word.
  function automatic logic [15:0] be_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] base;
    base = (16'd1 << (5'd1 << size)) - 16'd1;
    return base << off;
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Core request/response and word-memory bus of the data-memory access unit.
interface dmem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int BYTES = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTES-1:0]  mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dmem_load_extend.sv
// Sign/zero extension of right-justified load bytes to the full datapath width.
module dmem_load_extend
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] result
);
  localparam int SW = $clog2(XLEN) + 1;

  logic [SW-1:0]   nbits_s;
  logic [XLEN-1:0] mask_s;
  logic            msb_s;

  // Number of significant bits for the access size.
  always_comb begin
    nbits_s = SW'(XLEN);
    case (size)
      SZ_B:    nbits_s = SW'(8);
      SZ_H:    nbits_s = SW'(16);
      SZ_W:    nbits_s = SW'(32);
      default: nbits_s = SW'(XLEN);
    endcase
  end

  // Full-width loads get an all-ones mask, so nothing is replicated.
  assign mask_s = {XLEN{1'b1}} >> (SW'(XLEN) - nbits_s);
  assign msb_s  = (|(raw & mask_s & ~(mask_s >> 1))) & ~uns;
  assign result = (raw & mask_s) | ({XLEN{msb_s}} & ~mask_s);

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store access unit: byte enables, lane shifting, load extension and
// optional splitting of word-crossing accesses into two memory transactions.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input logic              clk,
  input logic              rst,
  dmem_access_unit_if.slave bus
);
  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  state_e            state_r;
  logic              we_r;
  logic              uns_r;
  logic              split_r;
  logic [1:0]        size_r;
  logic [OFF_W-1:0]  off_r;
  logic [ADDR_W-1:0] addr_r;
  logic [BYTES-1:0]  be_hi_r;
  logic [XLEN-1:0]   wdata_hi_r;
  logic [XLEN-1:0]   raw_r;

  logic [1:0]         size_s;
  logic [OFF_W-1:0]   off_s;
  logic [ADDR_W-1:0]  aligned_s;
  logic               illegal_s;
  logic [4:0]         end_s;
  logic               cross_s;
  logic [2*BYTES-1:0] be_wide_s;
  logic [2*XLEN-1:0]  wd_wide_s;
  logic [OFF_W:0]     rem_s;
  logic [XLEN-1:0]    merged_s;
  logic [XLEN-1:0]    ext_s;

  assign size_s    = bus.req_func3[1:0];
  assign off_s     = bus.req_addr[OFF_W-1:0];
  assign aligned_s = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign illegal_s = ((size_s == SZ_D) && (XLEN == 32)) || (bus.req_func3[2] && bus.req_we);
  assign end_s     = 5'(off_s) + (5'd1 << size_s);
  assign cross_s   = end_s > 5'(BYTES);
  assign be_wide_s = (2 * BYTES)'(be_mask(size_s, 3'(off_s)));
  assign wd_wide_s = {{XLEN{1'b0}}, bus.req_wdata} << {off_s, 3'b000};

  // Second word supplies the bytes above the BYTES-off already captured.
  assign rem_s    = (OFF_W + 1)'(BYTES) - {1'b0, off_r};
  assign merged_s = (state_r == ST_ACC1) ? (raw_r | (bus.mem_rdata << {rem_s, 3'b000}))
                                         : (bus.mem_rdata >> {off_r, 3'b000});

  dmem_load_extend #(.XLEN(XLEN)) u_extend (
    .raw    (merged_s),
    .size   (size_r),
    .uns    (uns_r),
    .result (ext_s)
  );

  // Access FSM with registered bus and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      we_r           <= 1'b0;
      uns_r          <= 1'b0;
      split_r        <= 1'b0;
      size_r         <= 2'b00;
      off_r          <= {OFF_W{1'b0}};
      addr_r         <= {ADDR_W{1'b0}};
      be_hi_r        <= {BYTES{1'b0}};
      wdata_hi_r     <= {XLEN{1'b0}};
      raw_r          <= {XLEN{1'b0}};
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= {XLEN{1'b0}};
      bus.resp_err   <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= {ADDR_W{1'b0}};
      bus.mem_be     <= {BYTES{1'b0}};
      bus.mem_wdata  <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_r          <= bus.req_we;
            uns_r         <= bus.req_func3[2];
            size_r        <= size_s;
            off_r         <= off_s;
            addr_r        <= aligned_s;
            split_r       <= cross_s;
            be_hi_r       <= be_wide_s[2*BYTES-1:BYTES];
            wdata_hi_r    <= wd_wide_s[2*XLEN-1:XLEN];
            raw_r         <= {XLEN{1'b0}};
            bus.req_ready <= 1'b0;
            if (illegal_s || (cross_s && (ALLOW_MISALIGNED == 0))) begin
              state_r        <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
            end else begin
              state_r       <= ST_ACC0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_we;
              bus.mem_addr  <= aligned_s;
              bus.mem_be    <= be_wide_s[BYTES-1:0];
              bus.mem_wdata <= wd_wide_s[XLEN-1:0];
            end
          end
        end
        ST_ACC0, ST_ACC1: begin
          if (bus.mem_ack) begin
            raw_r <= merged_s;
            if ((state_r == ST_ACC0) && split_r) begin
              state_r       <= ST_ACC1;
              bus.mem_addr  <= addr_r + ADDR_W'(BYTES);
              bus.mem_be    <= be_hi_r;
              bus.mem_wdata <= wdata_hi_r;
            end else begin
              state_r        <= ST_RESP;
              bus.mem_req    <= 1'b0;
              bus.mem_we     <= 1'b0;
              bus.mem_addr   <= {ADDR_W{1'b0}};
              bus.mem_be     <= {BYTES{1'b0}};
              bus.mem_wdata  <= {XLEN{1'b0}};
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= we_r ? {XLEN{1'b0}} : ext_s;
            end
          end
        end
        ST_RESP: begin
          state_r        <= ST_IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= {XLEN{1'b0}};
          bus.req_ready  <= 1'b1;
        end
        default: begin
          state_r       <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
